// File: rtl/fft_frame_loader_pkg.sv
// Shared constants and helpers for the 8-point FFT front end.
// Complex words carry the real part in the upper half and the imaginary part in the lower half.
package fft_pkg;

  localparam int CPLX_W = 64;
  localparam int N_PTS  = 8;
  localparam int LOG2N  = 3;

  localparam int RE_MSB = 63;
  localparam int RE_LSB = 32;
  localparam int IM_MSB = 31;
  localparam int IM_LSB = 0;

  typedef logic [LOG2N-1:0]  idx_t;
  typedef logic [CPLX_W-1:0] cplx_t;

  function automatic idx_t rev3(input idx_t k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample-in / frame-out handshake bundle between the loader and its neighbours.
// The slave side is the loader; the master side is the surrounding datapath.
interface fft_frame_loader_if;
  import fft_pkg::*;

  logic  s_valid;
  logic  s_ready;
  cplx_t s_data;
  logic  s_last;

  logic  m_valid;
  logic  m_ready;
  cplx_t m_d0, m_d1, m_d2, m_d3, m_d4, m_d5, m_d6, m_d7;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid,
    output m_d0, m_d1, m_d2, m_d3, m_d4, m_d5, m_d6, m_d7
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid,
    input  m_d0, m_d1, m_d2, m_d3, m_d4, m_d5, m_d6, m_d7
  );

endinterface

// File: rtl/fft_frame_loader_bank.sv
// One frame buffer: DEPTH x WIDTH registers, a single write port and all
// entries visible in parallel so the butterfly stage can read a whole frame at once.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata [DEPTH]
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader: collects 8 complex samples in bit-reversed slot order
// and presents each full frame in parallel until the consumer takes it.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int N_PTS  = 8,
  parameter int CPLX_W = 64,
  parameter int BITREV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  fft_frame_loader_if.slave   bus,
  output logic                frame_err,
  output logic [1:0]          occupancy
);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             frame_err_q, frame_err_d;

  logic             s_acc, m_acc, last_slot;
  logic [LOG2N-1:0] waddr;
  logic [CPLX_W-1:0] rdata_a [N_PTS];
  logic [CPLX_W-1:0] rdata_b [N_PTS];
  logic [CPLX_W-1:0] rd_sel  [N_PTS];

  assign bus.s_ready = !full_q[wr_bank_q];
  assign bus.m_valid = full_q[rd_bank_q];

  assign s_acc     = bus.s_valid && bus.s_ready;
  assign m_acc     = bus.m_valid && bus.m_ready;
  assign last_slot = (wr_cnt_q == LOG2N'(N_PTS - 1));
  assign waddr     = (BITREV != 0) ? rev3(wr_cnt_q) : wr_cnt_q;

  // Flush wins over both handshakes; a draining bank and a completing bank are
  // always different banks, so their flag updates never collide.
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    frame_err_d = 1'b0;
    if (flush) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_cnt_d  = '0;
    end else begin
      if (m_acc) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
      if (s_acc) begin
        if (last_slot) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = !wr_bank_q;
          wr_cnt_d          = '0;
        end else if (bus.s_last) begin
          wr_cnt_d    = '0;
          frame_err_d = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  fft_frame_bank #(.DEPTH(N_PTS), .WIDTH(CPLX_W)) u_bank_a (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (s_acc && !flush && !wr_bank_q),
    .waddr (waddr),
    .wdata (bus.s_data),
    .rdata (rdata_a)
  );

  fft_frame_bank #(.DEPTH(N_PTS), .WIDTH(CPLX_W)) u_bank_b (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (s_acc && !flush && wr_bank_q),
    .waddr (waddr),
    .wdata (bus.s_data),
    .rdata (rdata_b)
  );

  always_comb begin
    for (int k = 0; k < N_PTS; k++) rd_sel[k] = rd_bank_q ? rdata_b[k] : rdata_a[k];
  end

  assign bus.m_d0 = rd_sel[0];
  assign bus.m_d1 = rd_sel[1];
  assign bus.m_d2 = rd_sel[2];
  assign bus.m_d3 = rd_sel[3];
  assign bus.m_d4 = rd_sel[4];
  assign bus.m_d5 = rd_sel[5];
  assign bus.m_d6 = rd_sel[6];
  assign bus.m_d7 = rd_sel[7];

  assign frame_err = frame_err_q;
  assign occupancy = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: inputs change and outputs are sampled
// on the falling edge, expected frames are built from a bit-reversal model.
module tb_fft_frame_loader;
  import fft_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       frame_err;
  logic [1:0] occupancy;

  fft_frame_loader_if bus();

  fft_frame_loader #(.N_PTS(8), .CPLX_W(64), .BITREV(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .frame_err (frame_err),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] slot(input int k);
    case (k)
      0: return bus.m_d0;
      1: return bus.m_d1;
      2: return bus.m_d2;
      3: return bus.m_d3;
      4: return bus.m_d4;
      5: return bus.m_d5;
      6: return bus.m_d6;
      default: return bus.m_d7;
    endcase
  endfunction

  function automatic int brev(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  // Slot j of a frame whose samples were base, base+1, ... holds base + rev(j).
  task automatic check_frame(input string tag, input logic [63:0] base);
    for (int j = 0; j < 8; j++)
      chk($sformatf("%s_d%0d", tag, j), slot(j), base + 64'(brev(j)));
  endtask

  task automatic push(input logic [63:0] d, input logic last);
    int n;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    n = 0;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int frames, vld_cycles;
    logic prev_v;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_d0", bus.m_d0, 64'd0);
    chk("rst_d7", bus.m_d7, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", 64'(bus.s_ready), 64'd1);

    // Natural frame, consumer always ready
    bus.m_ready = 1'b1;
    for (int k = 0; k < 8; k++) push(64'(k), 1'b0);
    idle();
    chk("nat_m_valid", 64'(bus.m_valid), 64'd1);
    chk("nat_occ", 64'(occupancy), 64'd1);
    check_frame("nat", 64'd0);
    @(negedge clk);
    chk("nat_m_valid_drop", 64'(bus.m_valid), 64'd0);
    chk("nat_occ_drop", 64'(occupancy), 64'd0);

    // Backpressure: two frames held, third blocked
    bus.m_ready = 1'b0;
    for (int k = 16; k < 32; k++) push(64'(k), 1'b0);
    idle();
    chk("bp_s_ready_low", 64'(bus.s_ready), 64'd0);
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_m_valid", 64'(bus.m_valid), 64'd1);
    check_frame("bp_f1", 64'd16);
    bus.s_valid = 1'b1;
    bus.s_data  = 64'h99;
    repeat (2) @(negedge clk);
    bus.s_valid = 1'b0;
    chk("bp_stable_d1", bus.m_d1, 64'd20);
    chk("bp_stable_occ", 64'(occupancy), 64'd2);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk("bp_s_ready_back", 64'(bus.s_ready), 64'd1);
    chk("bp_occ1", 64'(occupancy), 64'd1);
    chk("bp_m_valid_f2", 64'(bus.m_valid), 64'd1);
    check_frame("bp_f2", 64'd24);
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("bp_drained_valid", 64'(bus.m_valid), 64'd0);
    chk("bp_drained_occ", 64'(occupancy), 64'd0);

    // Truncated frame followed by a good one
    push(64'd100, 1'b0);
    push(64'd101, 1'b0);
    push(64'd102, 1'b1);
    idle();
    chk("trunc_err_pulse", 64'(frame_err), 64'd1);
    chk("trunc_no_valid", 64'(bus.m_valid), 64'd0);
    @(negedge clk);
    chk("trunc_err_clear", 64'(frame_err), 64'd0);
    for (int k = 8; k < 16; k++) push(64'(k), 1'b0);
    idle();
    chk("trunc_next_valid", 64'(bus.m_valid), 64'd1);
    chk("trunc_next_d0", bus.m_d0, 64'd8);
    chk("trunc_next_d1", bus.m_d1, 64'd12);
    chk("trunc_next_d7", bus.m_d7, 64'd15);
    @(negedge clk);
    chk("trunc_next_drop", 64'(bus.m_valid), 64'd0);

    // Streaming: 64 samples back to back, consumer always ready
    frames = 0;
    vld_cycles = 0;
    prev_v = 1'b0;
    for (int c = 0; c < 68; c++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        vld_cycles++;
        if (prev_v) chk("stream_valid_one_cycle", 64'd1, 64'd0);
        check_frame($sformatf("stream_f%0d", frames), 64'd1000 + 64'(8 * frames));
        frames++;
      end
      prev_v = bus.m_valid;
      if (c < 64) begin
        chk("stream_s_ready", 64'(bus.s_ready), 64'd1);
        bus.s_valid = 1'b1;
        bus.s_data  = 64'd1000 + 64'(c);
      end else begin
        bus.s_valid = 1'b0;
      end
    end
    chk("stream_frames", 64'(frames), 64'd8);
    chk("stream_valid_cycles", 64'(vld_cycles), 64'd8);

    // Flush with one frame held and a partial frame in progress
    bus.m_ready = 1'b0;
    for (int k = 200; k < 208; k++) push(64'(k), 1'b0);
    for (int k = 300; k < 305; k++) push(64'(k), 1'b0);
    idle();
    chk("fl_pre_valid", 64'(bus.m_valid), 64'd1);
    chk("fl_pre_d0", bus.m_d0, 64'd200);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_m_valid", 64'(bus.m_valid), 64'd0);
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_s_ready", 64'(bus.s_ready), 64'd1);
    chk("fl_err", 64'(frame_err), 64'd0);
    bus.m_ready = 1'b1;
    for (int k = 400; k < 408; k++) push(64'(k), 1'b0);
    idle();
    chk("fl_next_valid", 64'(bus.m_valid), 64'd1);
    check_frame("fl_next", 64'd400);
    @(negedge clk);

    // Asynchronous reset between clock edges
    bus.m_ready = 1'b0;
    for (int k = 500; k < 508; k++) push(64'(k), 1'b0);
    for (int k = 600; k < 603; k++) push(64'(k), 1'b0);
    idle();
    chk("ar_pre_valid", 64'(bus.m_valid), 64'd1);
    chk("ar_pre_d0", bus.m_d0, 64'd500);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_m_valid", 64'(bus.m_valid), 64'd0);
    chk("ar_occ", 64'(occupancy), 64'd0);
    chk("ar_d0", bus.m_d0, 64'd0);
    chk("ar_d1", bus.m_d1, 64'd0);
    chk("ar_err", 64'(frame_err), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_s_ready", 64'(bus.s_ready), 64'd1);
    chk("ar_no_err", 64'(frame_err), 64'd0);
    bus.m_ready = 1'b1;
    for (int k = 700; k < 708; k++) push(64'(k), 1'b0);
    idle();
    chk("ar_next_valid", 64'(bus.m_valid), 64'd1);
    check_frame("ar_next", 64'd700);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Streaming front end for the 8-point radix-2 butterfly datapath.
- Accepts complex samples one per cycle over a valid/ready handshake and reorders them into bit-reversed index order.
- Presents each complete frame as eight parallel 64-bit words (m_d0..m_d7) that connect directly to the butterfly stage inputs.
- Ping-pong buffered: one frame fills while the previous frame is held for the consumer.

Parameters:
- N_PTS, 8, points per frame; fixed at 8, other values unsupported.
- CPLX_W, 64, complex word width: [63:32] real IEEE-754 single, [31:0] imag IEEE-754 single.
- BITREV, 1, 1 = store sample k at slot rev3(k); 0 = natural order.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of frame state.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample.
- s_data  in  64  complex sample.
- s_last  in  1  early end-of-frame marker; only meaningful before the 8th sample.
- m_valid  out  1  complete frame available.
- m_ready  in  1  consumer accepts frame.
- m_d0..m_d7  out  64 each  frame slots 0..7.
- frame_err  out  1  one-cycle pulse on a truncated frame.
- occupancy  out  2  number of full banks (0..2).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - m_valid=0, frame_err=0, occupancy=0, s_ready=1.
  - All bank storage = 0, so m_d0..m_d7 = 0.
  - wr_bank=0, rd_bank=0, wr_cnt=0.
- Storage: two banks (A/B) of 8 x 64-bit registers; full[1:0] flags.
- s_ready = !full[wr_bank], combinational from registered flags.
- Sample accept (s_valid && s_ready):
  - Write s_data into bank[wr_bank][BITREV ? rev3(wr_cnt) : wr_cnt].
  - rev3 map: 0→0, 1→4, 2→2, 3→6, 4→1, 5→5, 6→3, 7→7.
  - If wr_cnt==7: set full[wr_bank], toggle wr_bank, wr_cnt←0. s_last is ignored at this count.
  - Else if s_last=1: partial frame dropped (flag not set), wr_cnt←0, bank not toggled, frame_err=1 next cycle.
  - Else: wr_cnt←wr_cnt+1.
- Output side:
  - m_valid = full[rd_bank].
  - m_dk = bank[rd_bank][k], registered storage with combinational mux.
  - m_dk held stable while m_valid && !m_ready; m_valid never drops without a handshake, except on flush or reset.
  - On m_valid && m_ready: clear full[rd_bank], toggle rd_bank.
- Latency: 8th sample accepted at edge t → m_valid=1 after edge t, provided rd_bank points to that bank.
- Throughput: with m_ready tied high, continuous 8 samples / 8 cycles, s_ready never deasserts.
- Simultaneous events:
  - Completing a frame and draining the other bank in the same cycle: both take effect; occupancy unchanged.
  - Both banks full: s_ready=0; it returns to 1 the cycle after the next m_ready handshake.
  - s_valid with s_ready=0: no effect; upstream holds data.
- flush (synchronous, priority over all handshakes in that cycle):
  - full←0, wr_cnt←0, wr_bank←0, rd_bank←0, frame_err←0.
  - Bank data not cleared.
  - m_valid=0 from the next cycle.
- Reset mid-frame: all state cleared immediately (asynchronous); a partial frame is lost without frame_err.
- occupancy = full[0] + full[1].

Decomposition:
- Package fft_pkg:
  - CPLX_W=64, N_PTS=8, LOG2N=3.
  - Function rev3.
  - Complex field slice constants (RE_MSB=63, RE_LSB=32, IM_MSB=31, IM_LSB=0).
- Sub-module fft_frame_bank: 8x64 register file with asynchronous active-low reset, one write port (we, waddr[2:0], wdata), eight parallel read outputs.
  - Instantiated twice; the top holds counters, flags and the output mux.

Test Plan:
- Natural frame: send s_data=64'h0..64'h7 (k=0..7) back to back with m_ready=1 → m_valid one cycle after the 8th accept; m_d0..m_d7 = 0,4,2,6,1,5,3,7; m_valid held one cycle.
- Backpressure: m_ready=0, send 16 samples → s_ready drops after the 16th accept; occupancy=2; m_d* stable. Raise m_ready for 1 cycle → frame 1 drains, s_ready=1 next cycle, frame 2 on outputs.
- Truncated frame: 3 samples with s_last on the 3rd → frame_err pulses 1 cycle, no m_valid. Next 8 samples (tags 8..15) → m_d0=8, m_d1=12, m_d7=15.
- Streaming: 64 samples continuous with m_ready=1 → 8 frames, s_ready never low, each m_valid exactly 1 cycle, order matches a bit-reversal model.
- Flush mid-fill: 5 samples then flush=1 → m_valid=0, occupancy=0. Next full frame reorders correctly from slot 0.
- Async reset: assert rst_n=0 mid-frame between clock edges → m_valid, occupancy, m_d* go 0 immediately; after release s_ready=1.
